// File: rtl/sync_fifo_pkt.sv
// rtl/sync_fifo_pkt.sv - single-clock FIFO with FWFT read mode, packet commit/drop and level flags
module sync_fifo_pkt #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b0,
  parameter bit PKT_MODE   = 1'b0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  input  logic                  wr_drop,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so differences give occupancy directly.
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, commit_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] mem_level, avail;
  logic          out_valid, out_valid_nxt;
  logic          bad_frame, bad_frame_nxt;
  logic          wr_acc, rd_acc, reject, bad_eff;
  logic          do_drop, do_commit, fetch, mem_rd;

  always_comb begin
    mem_level    = wr_ptr - rd_ptr;
    avail        = commit_ptr - rd_ptr;
    level        = mem_level + PW'(out_valid);
    full         = (level == DEPTH_L);
    empty        = FWFT ? !out_valid : (avail == '0);
    almost_full  = (level >= AF_L);
    almost_empty = (level <= AE_L);
  end

  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    reject    = wr_en && full;
    // A rejected write poisons the open frame; a commit of a poisoned frame becomes a drop.
    bad_eff   = PKT_MODE && (bad_frame || reject);
    do_drop   = PKT_MODE && (wr_drop || (wr_commit && bad_eff));
    do_commit = PKT_MODE ? (wr_commit && !do_drop) : 1'b1;
    fetch     = FWFT && (!out_valid || rd_acc) && (avail != '0);
    mem_rd    = FWFT ? fetch : rd_acc;

    wr_ptr_nxt = wr_acc ? wr_ptr + 1'b1 : wr_ptr;
    if (do_drop) begin
      wr_ptr_nxt = commit_ptr;
    end
    commit_ptr_nxt = do_commit ? wr_ptr_nxt : commit_ptr;
    rd_ptr_nxt     = mem_rd ? rd_ptr + 1'b1 : rd_ptr;
    out_valid_nxt  = FWFT && (fetch || (out_valid && !rd_acc));
    bad_frame_nxt  = bad_eff && !do_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      bad_frame  <= 1'b0;
      rd_data    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      out_valid  <= out_valid_nxt;
      bad_frame  <= bad_frame_nxt;
      if (mem_rd) begin
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      overflow   <= reject;
      underflow  <= rd_en && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_pkt.sv
// tb/tb_sync_fifo_pkt.sv - scoreboard bench driving standard, FWFT and packet-mode instances in parallel
module tb_sync_fifo_pkt;

  localparam int DW    = 36;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  typedef logic [DW-1:0] word_q_t [$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0, wr_commit = 1'b0, wr_drop = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rdata [3];
  logic          emp [3], ful [3], ae [3], af [3], ovf [3], unf [3];
  logic [AW:0]   lvl [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: committed words, uncommitted words, expected read stream per instance.
  word_q_t qc0, qc1, qc2, qu0, qu1, qu2, exp0, exp1, exp2;
  bit      vis0, vis1, vis2, bad0, bad1, bad2;
  bit      ovf_m [3], unf_m [3];
  logic [10:0] exp_v [3];

  always #5 clk = ~clk;

  sync_fifo_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0), .PKT_MODE(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_drop(wr_drop), .rd_en(rd_en), .rd_data(rdata[0]), .empty(emp[0]), .full(ful[0]),
    .almost_empty(ae[0]), .almost_full(af[0]), .level(lvl[0]), .overflow(ovf[0]), .underflow(unf[0]));

  sync_fifo_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1), .PKT_MODE(1'b0)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_drop(wr_drop), .rd_en(rd_en), .rd_data(rdata[1]), .empty(emp[1]), .full(ful[1]),
    .almost_empty(ae[1]), .almost_full(af[1]), .level(lvl[1]), .overflow(ovf[1]), .underflow(unf[1]));

  sync_fifo_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0), .PKT_MODE(1'b1)) u_pkt (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_drop(wr_drop), .rd_en(rd_en), .rd_data(rdata[2]), .empty(emp[2]), .full(ful[2]),
    .almost_empty(ae[2]), .almost_full(af[2]), .level(lvl[2]), .overflow(ovf[2]), .underflow(unf[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step(input bit fwft, input bit pkt, inout word_q_t qc, inout word_q_t qu,
                            inout word_q_t ex, inout bit vis, inout bit bad,
                            output bit o, output bit u);
    int  held      = qc.size() + qu.size();
    bit  is_empty  = fwft ? !vis : (qc.size() == 0);
    int  mem_ready = qc.size() - ((fwft && vis) ? 1 : 0);
    bit  wr_ok     = wr_en && (held < DEPTH);
    bit  rd_ok     = rd_en && !is_empty;
    bit  bad_now, drop, commit;
    o = wr_en && !wr_ok;
    u = rd_en && is_empty;
    if (rd_ok) ex.push_back(qc.pop_front());
    if (wr_ok) qu.push_back(wr_data);
    bad_now = pkt && (bad || o);
    drop    = pkt && (wr_drop || (wr_commit && bad_now));
    commit  = !pkt || (wr_commit && !drop);
    if (drop) qu.delete();
    else if (commit) while (qu.size() > 0) qc.push_back(qu.pop_front());
    bad = bad_now && !drop;
    if (fwft) vis = (vis && !rd_ok) || (mem_ready > 0);
  endtask

  function automatic logic [10:0] exp_vec(input int n, input bit e, input bit o, input bit u);
    return {n[4:0], e, n == DEPTH, n <= AE, n >= AF, o, u};
  endfunction

  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit c, input bit dr, input bit r);
    wr_en = w; wr_data = d; wr_commit = c; wr_drop = dr; rd_en = r;
    if (rst) begin
      qc0.delete(); qc1.delete(); qc2.delete(); qu0.delete(); qu1.delete(); qu2.delete();
      vis0 = 0; vis1 = 0; vis2 = 0; bad0 = 0; bad1 = 0; bad2 = 0;
      for (int m = 0; m < 3; m++) begin ovf_m[m] = 0; unf_m[m] = 0; end
    end else begin
      model_step(1'b0, 1'b0, qc0, qu0, exp0, vis0, bad0, ovf_m[0], unf_m[0]);
      model_step(1'b1, 1'b0, qc1, qu1, exp1, vis1, bad1, ovf_m[1], unf_m[1]);
      model_step(1'b0, 1'b1, qc2, qu2, exp2, vis2, bad2, ovf_m[2], unf_m[2]);
    end
    exp_v[0] = exp_vec(qc0.size() + qu0.size(), qc0.size() == 0, ovf_m[0], unf_m[0]);
    exp_v[1] = exp_vec(qc1.size() + qu1.size(), !vis1, ovf_m[1], unf_m[1]);
    exp_v[2] = exp_vec(qc2.size() + qu2.size(), qc2.size() == 0, ovf_m[2], unf_m[2]);
    @(posedge clk);
    #1;
    cyc++;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("flags[%0d] {level,empty,full,ae,af,ovf,unf}", m),
          64'({lvl[m], emp[m], ful[m], ae[m], af[m], ovf[m], unf[m]}), 64'(exp_v[m]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, '0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic sb_pop(input string nm, input logic [DW-1:0] act, inout word_q_t ex);
    checks++;
    if (ex.size() == 0) begin
      errors++;
      $display("FAIL %s: read data %0h with no expected word queued (cycle %0d)", nm, act, cyc);
    end else begin
      logic [DW-1:0] e = ex.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, e, cyc);
      end
    end
  endtask

  // Monitor: standard-mode data appears the cycle after the handshake, FWFT data during it.
  initial begin
    bit pend0, pend2;
    pend0 = 0; pend2 = 0;
    forever begin
      @(negedge clk);
      if (pend0) sb_pop("rd_data std", rdata[0], exp0);
      if (pend2) sb_pop("rd_data pkt", rdata[2], exp2);
      if (rd_en && !emp[1] && !rst) sb_pop("rd_data fwft", rdata[1], exp1);
      pend0 = rd_en && !emp[0] && !rst;
      pend2 = rd_en && !emp[2] && !rst;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw;
    do_reset();
    for (int m = 0; m < 3; m++) chk($sformatf("reset rd_data[%0d]", m), 64'(rdata[m]), 64'(0));

    // Fill to capacity, overflow, drain, underflow.
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 1, 0, 0);
    chk("full after 16 writes", 64'(ful[0]), 64'(1));
    chk("level after 16 writes", 64'(lvl[0]), 64'(16));
    cycle(1, DW'(99), 1, 0, 0);
    chk("overflow pulse", 64'(ovf[0]), 64'(1));
    chk("level held at 16", 64'(lvl[0]), 64'(16));
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 0, 0, 1);
    chk("empty after drain", 64'(emp[0]), 64'(1));
    cycle(0, '0, 0, 0, 1);
    chk("underflow pulse", 64'(unf[0]), 64'(1));
    chk("rd_data holds on underflow", 64'(rdata[0]), 64'(15));

    // Simultaneous read and write at empty, mid-fill and full.
    cycle(1, DW'(100), 1, 0, 1);
    chk("rw at empty level", 64'(lvl[0]), 64'(1));
    for (int i = 1; i < 8; i++) cycle(1, DW'(100 + i), 1, 0, 0);
    cycle(1, DW'(108), 1, 0, 1);
    chk("rw at mid level", 64'(lvl[0]), 64'(8));
    for (int i = 0; i < 8; i++) cycle(1, DW'(110 + i), 1, 0, 0);
    cycle(1, DW'(120), 1, 0, 1);
    chk("rw at full level", 64'(lvl[0]), 64'(15));
    for (int i = 0; i < 18; i++) cycle(0, '0, 0, 0, 1);

    // Packet commit and drop.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, DW'(200 + i), 0, 0, 0);
    chk("pkt hidden before commit", 64'(emp[2]), 64'(1));
    cycle(0, '0, 1, 0, 0);
    chk("pkt visible after commit", 64'(emp[2]), 64'(0));
    for (int i = 0; i < 3; i++) cycle(1, DW'(210 + i), 0, 0, 0);
    cycle(0, '0, 0, 1, 0);
    chk("pkt level after drop", 64'(lvl[2]), 64'(5));
    for (int i = 0; i < 9; i++) cycle(0, '0, 0, 0, 1);

    // Overflow mid-frame turns the commit into a drop; next frame is clean.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, DW'(300 + i), 1, 0, 0);
    for (int i = 0; i < 14; i++) cycle(1, DW'(310 + i), 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    chk("bad frame dropped on commit", 64'(lvl[2]), 64'(4));
    cycle(1, DW'(330), 0, 0, 0);
    cycle(1, DW'(331), 0, 0, 0);
    cycle(1, DW'(332), 1, 0, 0);
    chk("next frame commits", 64'(lvl[2]), 64'(7));
    chk("next frame readable", 64'(emp[2]), 64'(0));
    for (int i = 0; i < 18; i++) cycle(0, '0, 0, 0, 1);

    // Reset mid-frame, then FWFT presentation latency.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, DW'(400 + i), 0, 0, 0);
    chk("pkt level before reset", 64'(lvl[2]), 64'(7));
    do_reset();
    for (int m = 0; m < 3; m++) chk($sformatf("mid-frame reset rd_data[%0d]", m), 64'(rdata[m]), 64'(0));
    cycle(1, DW'('hA5), 1, 0, 0);
    chk("fwft empty right after write", 64'(emp[1]), 64'(1));
    cycle(0, '0, 0, 0, 0);
    chk("fwft rd_data presented", 64'(rdata[1]), 64'('hA5));
    chk("fwft not empty", 64'(emp[1]), 64'(0));
    cycle(0, '0, 0, 0, 1);
    chk("fwft empty after pop", 64'(emp[1]), 64'(1));

    // Randomized traffic in write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      pw = ((i / 250) % 2 == 0) ? 70 : 30;
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(99) < pw, DW'({$urandom(), $urandom()}),
              $urandom_range(99) < 20, $urandom_range(99) < 4, $urandom_range(99) < (100 - pw));
      end
    end
    for (int i = 0; i < 20; i++) cycle(0, '0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 0);
    chk("scoreboard std drained", 64'(exp0.size()), 64'(0));
    chk("scoreboard fwft drained", 64'(exp1.size()), 64'(0));
    chk("scoreboard pkt drained", 64'(exp2.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_pkt.md
# sync_fifo_pkt

Parametrised single-clock FIFO for the MAC datapath, successor to the basic synchronous FIFO. Adds selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, a fill-level output, and overflow/underflow flags. Optional packet mode holds written words invisible to the reader until the frame is committered; a frame can also be dropped by rewinding. Sits between the MAC framer and the PCS 64b/66b encoder as the TX frame buffer, and in the RX path ahead of frame-check discard.

## Interface
- DATA_WIDTH, 36: word width (data + control bits).
- ADDR_WIDTH, 4: depth = 2^ADDR_WIDTH words; capacity is exactly DEPTH in all modes.
- FWFT, 0: 0 = standard read (data 1 cycle after rd_en); 1 = head word presented on rd_data whenever !empty.
- PKT_MODE, 0: 1 = writes stay hidden until wr_commit.
- AF_THRESH, DEPTH-2: almost_full when level >= AF_THRESH.
- AE_THRESH, 2: almost_empty when level <= AE_THRESH.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- wr_commit  in  1  PKT_MODE: publish all uncommitted words, including a same-cycle write
- wr_drop  in  1  PKT_MODE: discard all uncommitted words, including a same-cycle write
- rd_en  in  1  read request (FWFT: acknowledge/pop the presented word)
- rd_data  out  DATA_WIDTH  read word, registered
- empty  out  1  no readable word
- full  out  1  level == DEPTH
- almost_empty, almost_full  out  1  threshold flags
- level  out  ADDR_WIDTH+1  words held, committed + uncommitted + FWFT output register
- overflow  out  1  1-cycle pulse: wr_en while full
- underflow  out  1  1-cycle pulse: rd_en while empty

## Operation
- Reset (rst=1 at an edge): all pointers 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, overflow 0, underflow 0, bad-frame flag 0. Uncommitted data is lost. Memory contents are not cleared.
- Write accepted iff wr_en && !full. Full is evaluated before any same-cycle read, so a write at full is rejected even when a read happens in the same cycle.
- Read accepted iff rd_en && !empty. A read at empty is ignored and rd_data holds its value. A same-cycle write does not rescue a read at empty.
- Pointers wrap modulo DEPTH. Level arithmetic is ADDR_WIDTH+1 bits wide and never exceeds DEPTH or goes below 0.
- Packet mode keeps three pointers: rd_ptr, commit_ptr and wr_ptr (speculative).
  - full/level are computed from wr_ptr.
  - empty is computed from commit_ptr.
  - wr_commit sets commit_ptr to the post-write wr_ptr.
  - wr_drop sets wr_ptr to commit_ptr and reduces level by the number of discarded words.
  - When wr_commit and wr_drop are asserted together, drop wins.
- Bad frame (PKT_MODE): a rejected write (overflow) while uncommitted words exist, or any rejected write after the last commit, sets the bad flag. The next wr_commit then acts as wr_drop. The flag clears on that commit or on a drop.
- With PKT_MODE=0, wr_commit and wr_drop are ignored and every accepted write is committed immediately.
- FWFT=1: an output register prefetches from memory whenever it is empty, or is being popped, and committed data exists. empty = !output-register-valid. The output register counts toward level and capacity.

## Timing
- Standard mode: accepted write at edge k (committed at k) → empty=0 after edge k. rd_en accepted at edge k → rd_data valid after edge k.
- FWFT mode: word committed at edge k into an empty FIFO → rd_data valid and empty=0 after edge k+1. rd_en at edge k with further committed data → next word on rd_data after edge k; otherwise empty=1 after edge k.
- PKT_MODE: words are invisible until commit. With wr_commit at edge k, empty behaves as if every word were written at edge k.
- level, full and the almost flags update after the same edge as the accepted write, read or drop.
- overflow and underflow are registered and asserted for the one cycle after the offending edge.

## Test plan
- Reset, then DEPTH=16 writes of 0..15 with no reads: full=1 and level=16 after the 16th edge; a 17th write gives overflow=1 for one cycle and level stays 16. Then 16 reads return 0..15 in order; empty=1; one extra read gives underflow=1 and rd_data stays 15.
- Simultaneous read and write at levels 0, 8 and 16: level stays 8 at mid-fill; at full the write is rejected and level drops to 15; at empty the read is ignored and level rises to 1.
- FWFT=1: single write of 0xA5 → rd_data=0xA5 and empty=0 two edges after the write with no rd_en; rd_en pops it and empty=1 on the next cycle.
- PKT_MODE=1: write 5 words and confirm empty stays 1; commit → 5 words become readable. Write 3 more then wr_drop → level back to 5 and the reader sees only the first 5.
- PKT_MODE=1: fill past full mid-frame, then wr_commit → frame dropped, level equals the pre-frame value, bad flag cleared; the next frame commits normally.
- rst asserted mid-frame at level 7 → all outputs at reset values on the next cycle; the first subsequent write reads back correctly.
